// File: rtl/axichannel_logger_mc.sv
// axichannel_logger_mc
//   Multi-channel AXI-style valid/ready logger. Each of NUM_CH channels is a
//   one-entry register slice. It passes beats through and reports each transfer
//   to a log storage backend:
//     - a logb record (valid + payload) when an input beat is accepted
//     - a loge pulse when that beat leaves on the output side
//   Both log paths and the backend almost-full input pass through a
//   PIPE_DEPTH-stage register pipeline. log_en = 0 bypasses logging entirely.
//
// Optional feature: define LOGGER_STATS_EN to add the per-channel saturating
//   counters stat_logb_cnt and stat_stall_cnt.
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   log_en          1 = log transfers, 0 = pass-through bypass
//   in_valid/in_ready/in_data      per-channel input handshake (ch0 in LSBs)
//   out_valid/out_ready/out_data   per-channel output handshake
//   logb_valid/logb_data           begin records, fire-and-forget
//   loge_valid                     end record pulses
//   logb_almful                    backend almost-full
//   stat_logb_cnt/stat_stall_cnt   per-channel statistics (LOGGER_STATS_EN)
module axichannel_logger_mc #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         log_en,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            logb_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] logb_data,
    output logic [NUM_CH-1:0]            loge_valid,
    input  logic                         logb_almful
`ifdef LOGGER_STATS_EN
    ,
    output logic [NUM_CH*CNT_WIDTH-1:0]  stat_logb_cnt,
    output logic [NUM_CH*CNT_WIDTH-1:0]  stat_stall_cnt
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    if (NUM_CH < 1 || DATA_WIDTH < 1 || PIPE_DEPTH < 0 || CNT_WIDTH < 1) begin : g_bad_param
        $error("axichannel_logger_mc: illegal parameter value");
    end

    // Log stage input, before the PIPE_DEPTH delay line.
    logic                         almful_p;
    logic [NUM_CH-1:0]            logb_valid_p;
    logic [NUM_CH*DATA_WIDTH-1:0] logb_data_p;
    logic [NUM_CH-1:0]            loge_valid_p;

    // ------------------------------------------------------------------
    // Per-channel register slice
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [0:0]            state_q;
        logic [0:0]            state_d;
        logic                  logged_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  fire_out;
        logic                  accept;

        assign out_valid[c] = (state_q == ST_FULL);
        assign fire_out     = out_valid[c] & out_ready[c];
        // A draining slot can take a new beat in the same cycle, so in_ready
        // follows out_ready combinationally. almful only throttles while logging.
        assign in_ready[c]  = ((state_q == ST_EMPTY) | fire_out) & (~log_en | ~almful_p);
        assign accept       = in_valid[c] & in_ready[c];

        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_EMPTY: if (accept)               state_d = ST_FULL;
                ST_FULL:  if (fire_out && !accept)  state_d = ST_EMPTY;
                default:                            state_d = ST_EMPTY;
            endcase
        end

        // NOTE: clocked state uses non-blocking assignments. All flops then
        // sample pre-edge values, whatever order the blocks are evaluated in.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= ST_EMPTY;
                logged_q <= 1'b0;
            end else begin
                state_q <= state_d;
                if (accept) logged_q <= log_en;
            end
        end

        // NOTE: payload registers have no reset. state_q / the valid bits
        // qualify them, so resetting them would only add reset fan-out.
        always_ff @(posedge clk) begin
            if (accept) data_q <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
        end

        assign out_data[c*DATA_WIDTH +: DATA_WIDTH]    = data_q;
        assign logb_valid_p[c]                         = accept & log_en;
        assign logb_data_p[c*DATA_WIDTH +: DATA_WIDTH] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
        // The logged flag is captured at accept time. A later log_en change
        // therefore neither suppresses nor invents a loge for the held beat.
        assign loge_valid_p[c]                         = fire_out & logged_q;

`ifdef LOGGER_STATS_EN
        logic [CNT_WIDTH-1:0] logb_cnt_q;
        logic [CNT_WIDTH-1:0] stall_cnt_q;
        logic                 stall;

        // Cycles where the slot could take the offered beat but almful holds it off.
        assign stall = in_valid[c] & log_en & almful_p & ((state_q == ST_EMPTY) | fire_out);

        always_ff @(posedge clk) begin
            if (rst) begin
                logb_cnt_q  <= '0;
                stall_cnt_q <= '0;
            end else begin
                if (logb_valid_p[c] && logb_cnt_q != '1) logb_cnt_q  <= logb_cnt_q + 1'b1;
                if (stall && stall_cnt_q != '1)          stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end

        assign stat_logb_cnt[c*CNT_WIDTH +: CNT_WIDTH]  = logb_cnt_q;
        assign stat_stall_cnt[c*CNT_WIDTH +: CNT_WIDTH] = stall_cnt_q;
`endif
    end

    // ------------------------------------------------------------------
    // Log / almful delay lines
    // ------------------------------------------------------------------
    if (PIPE_DEPTH == 0) begin : g_comb
        assign almful_p   = logb_almful;
        assign logb_valid = logb_valid_p;
        assign logb_data  = logb_data_p;
        assign loge_valid = loge_valid_p;
    end else begin : g_pipe
        logic                         almful_sr [PIPE_DEPTH];
        logic [NUM_CH-1:0]            logb_v_sr [PIPE_DEPTH];
        logic [NUM_CH-1:0]            loge_v_sr [PIPE_DEPTH];
        logic [NUM_CH*DATA_WIDTH-1:0] logb_d_sr [PIPE_DEPTH];

        // almful stages reset to 1. Inputs therefore stay blocked until the
        // backend's real almost-full state has propagated through the pipeline.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < PIPE_DEPTH; i++) begin
                    almful_sr[i] <= 1'b1;
                    logb_v_sr[i] <= '0;
                    loge_v_sr[i] <= '0;
                end
            end else begin
                almful_sr[0] <= logb_almful;
                logb_v_sr[0] <= logb_valid_p;
                loge_v_sr[0] <= loge_valid_p;
                for (int i = 1; i < PIPE_DEPTH; i++) begin
                    almful_sr[i] <= almful_sr[i-1];
                    logb_v_sr[i] <= logb_v_sr[i-1];
                    loge_v_sr[i] <= loge_v_sr[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            logb_d_sr[0] <= logb_data_p;
            for (int i = 1; i < PIPE_DEPTH; i++) logb_d_sr[i] <= logb_d_sr[i-1];
        end

        assign almful_p   = almful_sr[PIPE_DEPTH-1];
        assign logb_valid = logb_v_sr[PIPE_DEPTH-1];
        assign logb_data  = logb_d_sr[PIPE_DEPTH-1];
        assign loge_valid = loge_v_sr[PIPE_DEPTH-1];
    end

endmodule

// File: tb/tb_axichannel_logger_mc.sv
// tb_axichannel_logger_mc
//   Directed + randomized bench for axichannel_logger_mc (NUM_CH=2,
//   DATA_WIDTH=32, PIPE_DEPTH=4). A transaction-level reference model tracks:
//     - the beat held in each channel slot
//     - log records scheduled PIPE_DEPTH cycles ahead
//     - the almful history since reset release
//   DUT outputs are compared on the falling edge.
module tb_axichannel_logger_mc;

    localparam int NC = 2;
    localparam int DW = 32;
    localparam int P  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              log_en;
    logic [NC-1:0]     in_valid;
    logic [NC-1:0]     in_ready;
    logic [NC*DW-1:0]  in_data;
    logic [NC-1:0]     out_valid;
    logic [NC-1:0]     out_ready;
    logic [NC*DW-1:0]  out_data;
    logic [NC-1:0]     logb_valid;
    logic [NC*DW-1:0]  logb_data;
    logic [NC-1:0]     loge_valid;
    logic              logb_almful;
`ifdef LOGGER_STATS_EN
    logic [NC*32-1:0]  stat_logb_cnt;
    logic [NC*32-1:0]  stat_stall_cnt;
    logic [NC-1:0]     s_in_ready;
    logic [NC-1:0]     s_out_valid;
    logic [NC*DW-1:0]  s_out_data;
    logic [NC-1:0]     s_logb_valid;
    logic [NC*DW-1:0]  s_logb_data;
    logic [NC-1:0]     s_loge_valid;
    logic [NC*4-1:0]   s_stat_logb_cnt;
    logic [NC*4-1:0]   s_stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    axichannel_logger_mc #(.NUM_CH(NC), .DATA_WIDTH(DW), .PIPE_DEPTH(P), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .log_en(log_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .logb_valid(logb_valid), .logb_data(logb_data), .loge_valid(loge_valid),
        .logb_almful(logb_almful)
`ifdef LOGGER_STATS_EN
        , .stat_logb_cnt(stat_logb_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

`ifdef LOGGER_STATS_EN
    // Narrow-counter copy driven identically, used only for saturation checks.
    axichannel_logger_mc #(.NUM_CH(NC), .DATA_WIDTH(DW), .PIPE_DEPTH(P), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .log_en(log_en),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .logb_valid(s_logb_valid), .logb_data(s_logb_data), .loge_valid(s_loge_valid),
        .logb_almful(logb_almful),
        .stat_logb_cnt(s_stat_logb_cnt), .stat_stall_cnt(s_stat_stall_cnt)
    );
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          logged;
    } beat_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    beat_t         hold_q [NC][$];
    bit            logb_v_exp [NC][64];
    logic [DW-1:0] logb_d_exp [NC][64];
    bit            loge_exp   [NC][64];
    bit            alm_hist   [64];
    int            cyc       = 0;
    int            since_rst = 0;
    int            rst_cyc   = 0;
    int            logb_n  [NC];
    int            stall_n [NC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: compare on the falling edge, advance the model, and
    // return just after the rising edge so the caller can drive new inputs.
    task automatic cycle();
        bit    hv, fire, rdy, acc, alm_p, stall;
        int    slot, fut;
        beat_t b;
        @(negedge clk);
        if (rst) begin
            if (rst_cyc > 0) begin
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_logb_valid", 64'(logb_valid), 64'd0);
                chk("rst_loge_valid", 64'(loge_valid), 64'd0);
`ifdef LOGGER_STATS_EN
                chk("rst_stat_logb", 64'(stat_logb_cnt), 64'd0);
                chk("rst_stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
            end
            rst_cyc++;
            since_rst = 0;
            for (int c = 0; c < NC; c++) begin
                hold_q[c].delete();
                logb_n[c]  = 0;
                stall_n[c] = 0;
                for (int s = 0; s < 64; s++) begin
                    logb_v_exp[c][s] = 1'b0;
                    loge_exp[c][s]   = 1'b0;
                end
            end
        end else begin
            rst_cyc = 0;
            alm_p = (since_rst < P) ? 1'b1 : alm_hist[(cyc - P) % 64];
            slot  = cyc % 64;
            fut   = (cyc + P) % 64;
            for (int c = 0; c < NC; c++) begin
                hv    = hold_q[c].size() > 0;
                fire  = hv && out_ready[c];
                rdy   = (!hv || fire) && (!log_en || !alm_p);
                acc   = in_valid[c] && rdy;
                stall = in_valid[c] && log_en && alm_p && (!hv || fire);
                chk($sformatf("ch%0d_in_ready", c), 64'(in_ready[c]), 64'(rdy));
                chk($sformatf("ch%0d_out_valid", c), 64'(out_valid[c]), 64'(hv));
                if (hv)
                    chk($sformatf("ch%0d_out_data", c), 64'(out_data[c*DW +: DW]), 64'(hold_q[c][0].data));
                chk($sformatf("ch%0d_logb_valid", c), 64'(logb_valid[c]), 64'(logb_v_exp[c][slot]));
                if (logb_v_exp[c][slot])
                    chk($sformatf("ch%0d_logb_data", c), 64'(logb_data[c*DW +: DW]), 64'(logb_d_exp[c][slot]));
                chk($sformatf("ch%0d_loge_valid", c), 64'(loge_valid[c]), 64'(loge_exp[c][slot]));
                logb_v_exp[c][slot] = 1'b0;
                loge_exp[c][slot]   = 1'b0;
`ifdef LOGGER_STATS_EN
                chk($sformatf("ch%0d_stat_logb", c), 64'(stat_logb_cnt[c*32 +: 32]), 64'(logb_n[c]));
                chk($sformatf("ch%0d_stat_stall", c), 64'(stat_stall_cnt[c*32 +: 32]), 64'(stall_n[c]));
                chk($sformatf("ch%0d_sat_logb", c), 64'(s_stat_logb_cnt[c*4 +: 4]),
                    64'((logb_n[c] > 15) ? 15 : logb_n[c]));
                chk($sformatf("ch%0d_sat_stall", c), 64'(s_stat_stall_cnt[c*4 +: 4]),
                    64'((stall_n[c] > 15) ? 15 : stall_n[c]));
`endif
                if (fire) begin
                    b = hold_q[c].pop_front();
                    if (b.logged) loge_exp[c][fut] = 1'b1;
                end
                if (acc) begin
                    hold_q[c].push_back('{data: in_data[c*DW +: DW], logged: log_en});
                    if (log_en) begin
                        logb_v_exp[c][fut] = 1'b1;
                        logb_d_exp[c][fut] = in_data[c*DW +: DW];
                        logb_n[c]++;
                    end
                end
                if (stall) stall_n[c]++;
            end
            alm_hist[slot] = logb_almful;
            since_rst++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        in_data = {$urandom(), $urandom()};
    endtask

    initial begin
        // Reset: 3 cycles, then the almful pipeline blocks inputs for 4 cycles.
        rst = 1'b1; log_en = 1'b1; in_valid = '0; out_ready = '0; logb_almful = 1'b0; in_data = '0;
        repeat (3) cycle();
        rst = 1'b0; in_valid = 2'b11; out_ready = 2'b11;
        repeat (8) begin rand_data(); cycle(); end
        in_valid = '0;
        repeat (8) cycle();

        // Single ch0 beat held for 3 cycles before the output fires.
        in_valid = 2'b01; out_ready = 2'b00; in_data = {32'h0, 32'hA5A50001};
        cycle();
        in_valid = '0;
        repeat (2) cycle();
        out_ready = 2'b01;
        cycle();
        out_ready = 2'b00;
        repeat (8) cycle();

        // Two 8-beat streams at full rate.
        out_ready = 2'b11; in_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            in_data = {32'(100 + i), 32'(i)};
            cycle();
        end
        in_valid = '0;
        repeat (8) cycle();

        // Back-pressure from almful while both channels stream.
        in_valid = 2'b11;
        for (int i = 0; i < 30; i++) begin
            logb_almful = (i >= 5 && i < 15);
            out_ready   = 2'($urandom_range(0, 3) | ((i % 3 == 0) ? 2'b00 : 2'b11));
            rand_data();
            cycle();
        end
        in_valid = '0; logb_almful = 1'b0; out_ready = 2'b11;
        repeat (8) cycle();

        // Bypass ignores almful and produces no log records.
        log_en = 1'b0; logb_almful = 1'b1;
        in_valid = 2'b11; in_data = {32'h22, 32'h11};
        cycle();
        in_data = {32'h11, 32'h22};
        cycle();
        in_valid = '0;
        repeat (6) cycle();
        // A logged beat keeps its loge after log_en falls.
        log_en = 1'b1; logb_almful = 1'b0;
        repeat (5) cycle();
        out_ready = 2'b00; in_valid = 2'b01; in_data = {32'h0, 32'hC0DE0001};
        cycle();
        in_valid = '0; log_en = 1'b0;
        repeat (2) cycle();
        out_ready = 2'b11;
        repeat (6) cycle();
        // An unlogged beat gets no loge after log_en rises.
        out_ready = 2'b00; in_valid = 2'b10; in_data = {32'hBEEF0002, 32'h0};
        cycle();
        in_valid = '0; log_en = 1'b1;
        repeat (2) cycle();
        out_ready = 2'b11;
        repeat (8) cycle();

        // Randomized soak covering log_en, almful and out_ready.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 2'($urandom_range(0, 3));
            out_ready = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) logb_almful = ~logb_almful;
            if ($urandom_range(0, 31) == 0) log_en = ~log_en;
            rand_data();
            cycle();
        end

        // Reset in the middle of traffic discards held beats and in-flight records.
        log_en = 1'b1; logb_almful = 1'b0; in_valid = 2'b11; out_ready = 2'b10;
        repeat (6) begin rand_data(); cycle(); end
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0; in_valid = '0; out_ready = 2'b11;
        repeat (12) cycle();

        // Stall accounting after reset: 6 almful stall cycles on ch1 only.
        repeat (6) cycle();
        logb_almful = 1'b1;
        repeat (P) cycle();
        in_valid = 2'b10;
        repeat (6) begin rand_data(); cycle(); end
        in_valid = '0; logb_almful = 1'b0;
        repeat (P + 2) cycle();
        // Then 5 logged beats on ch1.
        in_valid = 2'b10;
        repeat (5) begin rand_data(); cycle(); end
        in_valid = '0;
        repeat (8) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
